fft_out_serializer: RTL and testbench

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

---
 rtl/fft_out_serializer.sv | 130 +++++++++++++
 tb/tb_fft_out_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: double-buffered parallel-to-serial converter for FFT
// output frames, with optional bit-reversed read order and drop detection.

package fft_out_serializer_pkg;
  parameter int DW = 16;
  typedef struct packed {
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] i;
  } complex_product_t;
endpackage

// One frame index worth of storage: the entry for this index in each bank.
module fft_ser_lane
  import fft_out_serializer_pkg::*;
(
  input  logic             clk,
  input  logic [1:0]       we,
  input  complex_product_t d,
  output complex_product_t q0,
  output complex_product_t q1
);
  // Bank storage carries no reset; the full flags decide what is valid.
  always_ff @(posedge clk) begin
    if (we[0]) q0 <= d;
    if (we[1]) q1 <= d;
  end
endmodule

module fft_out_serializer
  import fft_out_serializer_pkg::*;
#(
  parameter int N           = 8,
  parameter int BIT_REVERSE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  complex_product_t [N-1:0] fft_in,
  output logic                     in_ready,
  output complex_product_t         data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N)-1:0]     sample_idx,
  output logic                     frame_last,
  output logic                     overflow,
  input  logic                     clear_ovf
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N-1);

  logic [1:0]              full, full_nxt;
  logic                    wr_bank, rd_bank;
  logic [AW-1:0]           rd_idx, rd_j;
  logic                    capture, drop, xfer, xfer_last;
  logic [1:0]              bank_we;
  complex_product_t [N-1:0] q0, q1;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
    logic [AW-1:0] y;
    for (int b = 0; b < AW; b++) y[b] = x[AW-1-b];
    return y;
  endfunction

  // Handshake decode; in_ready comes only from registered state so a
  // same-cycle free cannot open the door for an arriving frame.
  always_comb begin
    in_ready  = !full[wr_bank];
    out_valid = full[rd_bank];
    capture   = in_valid && in_ready;
    drop      = in_valid && !in_ready;
    xfer      = out_valid && out_ready;
    xfer_last = xfer && (rd_idx == LAST_IDX);
    bank_we   = {capture && wr_bank, capture && !wr_bank};
  end

  // Capture sets the write bank's flag while a final transfer clears the
  // read bank's; both can happen in one cycle and never hit the same bank.
  always_comb begin
    full_nxt = full;
    if (capture)   full_nxt[wr_bank] = 1'b1;
    if (xfer_last) full_nxt[rd_bank] = 1'b0;
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      fft_ser_lane u_lane (
        .clk (clk),
        .we  (bank_we),
        .d   (fft_in[g]),
        .q0  (q0[g]),
        .q1  (q1[g])
      );
    end
  endgenerate

  // Bank pointers, read index and full flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else begin
      full <= full_nxt;
      if (capture) wr_bank <= ~wr_bank;
      if (xfer_last) begin
        rd_idx  <= '0;
        rd_bank <= ~rd_bank;
      end else if (xfer) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Sticky drop flag; a drop beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  // Serial read mux in natural or bit-reversed order.
  always_comb begin
    rd_j       = (BIT_REVERSE != 0) ? bitrev(rd_idx) : rd_idx;
    data_out   = rd_bank ? q1[rd_j] : q0[rd_j];
    sample_idx = out_valid ? rd_idx : '0;
    frame_last = out_valid && (rd_idx == LAST_IDX);
  end
endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer (N=8), bit-reversed and natural order.
module tb_fft_out_serializer;
  import fft_out_serializer_pkg::*;

  typedef complex_product_t [7:0] frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic clear_ovf = 1'b0;
  frame_t fft_in = '0;

  logic in_ready, out_valid, frame_last, overflow;
  logic [2:0] sample_idx;
  complex_product_t data_out;
  logic in_ready_n, out_valid_n, frame_last_n, overflow_n;
  logic [2:0] sample_idx_n;
  complex_product_t data_out_n;

  int checks = 0;
  int failures = 0;
  int brev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  fft_out_serializer #(.N(8), .BIT_REVERSE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .fft_in(fft_in),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .sample_idx(sample_idx), .frame_last(frame_last),
    .overflow(overflow), .clear_ovf(clear_ovf)
  );

  fft_out_serializer #(.N(8), .BIT_REVERSE(0)) dut_nr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .fft_in(fft_in),
    .in_ready(in_ready_n), .data_out(data_out_n), .out_valid(out_valid_n),
    .out_ready(out_ready), .sample_idx(sample_idx_n), .frame_last(frame_last_n),
    .overflow(overflow_n), .clear_ovf(clear_ovf)
  );

  function automatic frame_t mk_frame(input int base);
    frame_t f;
    for (int k = 0; k < 8; k++) begin
      f[k].r = 16'(base + k);
      f[k].i = 16'(-k);
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int base);
    fft_in   = mk_frame(base);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Check the bit-reversed stream sample s of a frame whose r values are base+k.
  task automatic chk_sample(input string nm, input int base, input int s);
    checks++;
    if (out_valid !== 1'b1 || sample_idx !== 3'(s) || frame_last !== (s == 7) ||
        data_out.r !== 16'(base + brev[s]) || data_out.i !== 16'(-brev[s])) begin
      failures++;
      $display("FAIL %s s=%0d: got v=%b idx=%0d last=%b r=%0d i=%0d, want v=1 idx=%0d last=%b r=%0d i=%0d",
               nm, s, out_valid, sample_idx, frame_last, data_out.r, data_out.i,
               s, (s == 7), base + brev[s], -brev[s]);
    end
  endtask

  task automatic chk_idle(input string nm);
    checks++;
    if (out_valid !== 1'b0 || sample_idx !== 3'd0 || frame_last !== 1'b0) begin
      failures++;
      $display("FAIL %s: got v=%b idx=%0d last=%b, want 0 0 0", nm, out_valid, sample_idx, frame_last);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sample_idx !== 3'd0 ||
        frame_last !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: got v=%b rdy=%b idx=%0d last=%b ovf=%b, want 0 1 0 0 0",
               out_valid, in_ready, sample_idx, frame_last, overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bitrev();
    out_ready = 1'b1;
    present(0);
    for (int s = 0; s < 8; s++) begin
      chk_sample("bitrev", 0, s);
      tick();
    end
    chk_idle("bitrev_end");
  endtask

  task automatic test_natural();
    out_ready = 1'b1;
    present(0);
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (out_valid_n !== 1'b1 || data_out_n.r !== 16'(s) || frame_last_n !== (s == 7)) begin
        failures++;
        $display("FAIL natural s=%0d: got v=%b r=%0d last=%b, want 1 %0d %b",
                 s, out_valid_n, data_out_n.r, frame_last_n, s, (s == 7));
      end
      tick();
    end
    checks++;
    if (out_valid_n !== 1'b0) begin
      failures++;
      $display("FAIL natural_end: got v=%b want 0", out_valid_n);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    present(0);
    chk_sample("bp", 0, 0); tick();
    chk_sample("bp", 0, 1); tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_sample("bp_hold", 0, 2);
      tick();
    end
    out_ready = 1'b1;
    for (int s = 2; s < 8; s++) begin
      chk_sample("bp_resume", 0, s);
      tick();
    end
    chk_idle("bp_end");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    present(10);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ovf_rdy1: got in_ready=%b want 1", in_ready);
    end
    present(20);
    checks++;
    if (in_ready !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_rdy2: got in_ready=%b ovf=%b want 0 0", in_ready, overflow);
    end
    present(30);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got ovf=%b want 1", overflow);
    end
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin chk_sample("ovf_f1", 10, s); tick(); end
    for (int s = 0; s < 8; s++) begin chk_sample("ovf_f2", 20, s); tick(); end
    chk_idle("ovf_end");
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    present(40);
    for (int s = 0; s < 7; s++) begin chk_sample("b2b_f1", 40, s); tick(); end
    chk_sample("b2b_f1", 40, 7);
    present(50);
    for (int s = 0; s < 8; s++) begin chk_sample("b2b_f2", 50, s); tick(); end
    chk_idle("b2b_end");
  endtask

  task automatic test_full_drop();
    out_ready = 1'b0;
    present(60);
    present(70);
    out_ready = 1'b1;
    for (int s = 0; s < 7; s++) tick();
    chk_sample("fd_last", 60, 7);
    checks++;
    if (in_ready !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fd_rdy: got in_ready=%b ovf=%b want 0 0", in_ready, overflow);
    end
    present(80);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL fd_ovf: got ovf=%b want 1", overflow);
    end
    for (int s = 0; s < 8; s++) begin chk_sample("fd_f2", 70, s); tick(); end
    chk_idle("fd_end");
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    present(90);
    present(100);
    out_ready = 1'b1;
    for (int s = 0; s < 5; s++) tick();
    chk_sample("rm_pre", 90, 5);
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sample_idx !== 3'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rm_async: got v=%b rdy=%b idx=%0d ovf=%b want 0 1 0 0",
               out_valid, in_ready, sample_idx, overflow);
    end
    tick();
    reset = 1'b0;
    tick();
    chk_idle("rm_idle");
    present(110);
    for (int s = 0; s < 8; s++) begin chk_sample("rm_new", 110, s); tick(); end
    chk_idle("rm_end");
  endtask

  initial begin
    test_reset();
    test_bitrev();
    test_natural();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_full_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
